// File: rtl/aes_lite_pkg.sv
// Shared types and constant tables for the aes_lite toy cipher:
// FSM state encoding, round constants and the AES forward S-box.
package aes_lite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] RCON [1:8] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round counts outside 1..8 never occur in ROUND; they map to zero.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        if (r >= 4'd1 && r <= 4'd8) v = RCON[r];
        return v;
    endfunction

endpackage

// File: rtl/aes_lite_if.sv
// TinyTapeout-style pin bundle for aes_lite: enable, data/key bytes in,
// ciphertext, status and output-enable bytes out.
interface aes_lite_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/aes_lite_sbox.sv
// Combinational AES forward S-box: one table lookup, no state.
module aes_lite_sbox
    import aes_lite_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);
    assign y = SBOX[x];
endmodule

// File: rtl/aes_lite.sv
// Iterative toy 8-bit AES-style cipher, one round per enabled clock.
// Optional macro AES_LITE_DEBUG_EN exposes round_count and state on uio_out.
module aes_lite
    import aes_lite_pkg::*;
#(
    parameter int ROUNDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    aes_lite_if.slave     bus
);
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

    state_t     state;
    logic [3:0] round_count;
    logic [7:0] st;
    logic [7:0] rk;

    logic [7:0] rk_next;
    logic [7:0] sb;
    logic [7:0] st_next;
    logic       ready;

    aes_lite_sbox u_sbox (
        .x (st),
        .y (sb)
    );

    // Key schedule and round function both use the current round number.
    assign rk_next = {rk[6:0], rk[7]} ^ rcon_lookup(round_count);
    assign st_next = {sb[3:0], sb[7:4]} ^ rk_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            round_count <= 4'd0;
            st          <= 8'h00;
            rk          <= 8'h00;
        end else if (bus.ena) begin
            case (state)
                IDLE: begin
                    state <= LOAD;
                end
                LOAD: begin
                    st          <= bus.ui_in ^ bus.uio_in;
                    rk          <= bus.uio_in;
                    round_count <= 4'd1;
                    state       <= ROUND;
                end
                ROUND: begin
                    st <= st_next;
                    rk <= rk_next;
                    if (round_count == LAST_ROUND) begin
                        state <= DONE;
                    end else begin
                        round_count <= round_count + 4'd1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready      = (state == DONE);
    assign bus.uo_out = ready ? st : 8'h00;

`ifdef AES_LITE_DEBUG_EN
    assign bus.uio_out = {round_count, 2'(state), 1'b0, ready};
    assign bus.uio_oe  = 8'hFD;
`else
    assign bus.uio_out = {7'b0, ready};
    assign bus.uio_oe  = 8'h01;
`endif

endmodule

// File: tb/tb_aes_lite.sv
// Scoreboard bench for aes_lite: three instances (ROUNDS 1, 2, 4) share stimulus;
// expected ciphertexts come from a GF(2^8)-derived S-box model.
module tb_aes_lite;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_lite_if if1 ();
    aes_lite_if if2 ();
    aes_lite_if if4 ();

    aes_lite #(.ROUNDS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    aes_lite #(.ROUNDS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    aes_lite #(.ROUNDS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    localparam int RND [3] = '{1, 2, 4};
    logic [7:0] q [3][$];
    logic [7:0] mon_out [3];
    logic       mon_rdy [3];
    logic       prev_rdy [3];
    logic [7:0] sbox_tab [256];

    assign mon_out[0] = if1.uo_out;
    assign mon_out[1] = if2.uo_out;
    assign mon_out[2] = if4.uo_out;
    assign mon_rdy[0] = if1.uio_out[0];
    assign mon_rdy[1] = if2.uio_out[0];
    assign mon_rdy[2] = if4.uio_out[0];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_tab[x] = b ^ rotl1(b) ^ rotl1(rotl1(b)) ^ rotl1(rotl1(rotl1(b)))
                          ^ rotl1(rotl1(rotl1(rotl1(b)))) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic [7:0] k, input int rounds);
        logic [7:0] s, key, t;
        s = d ^ k;
        key = k;
        for (int r = 1; r <= rounds; r++) begin
            key = rotl1(key) ^ (8'h01 << (r - 1));
            t   = sbox_tab[s];
            s   = {t[3:0], t[7:4]} ^ key;
        end
        return s;
    endfunction

    task automatic set_in(input logic e, input logic [7:0] d, input logic [7:0] k);
        if1.ena = e; if2.ena = e; if4.ena = e;
        if1.ui_in = d; if2.ui_in = d; if4.ui_in = d;
        if1.uio_in = k; if2.uio_in = k; if4.uio_in = k;
    endtask

    task automatic push_model(input logic [7:0] d, input logic [7:0] k);
        for (int i = 0; i < 3; i++) q[i].push_back(model(d, k, RND[i]));
    endtask

    // Monitor: one ciphertext pop per rising ready; outputs must read zero otherwise.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (armed && mon_rdy[i] === 1'b1 && prev_rdy[i] !== 1'b1) begin
                if (q[i].size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_ready_r%0d: ready=1 with nothing pending, required ready=0", RND[i]);
                end else begin
                    check($sformatf("ciphertext_r%0d", RND[i]), mon_out[i], q[i].pop_front());
                end
            end else if (armed && mon_rdy[i] !== 1'b1) begin
                check($sformatf("idle_out_r%0d", RND[i]), mon_out[i], 8'h00);
            end
            prev_rdy[i] = mon_rdy[i];
        end
    end

    task automatic start(input logic [7:0] d, input logic [7:0] k);
        set_in(1'b1, d, k);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        armed = 1'b1;
        check("reset_uo_out", if4.uo_out, 8'h00);
        check("reset_ready", {7'b0, if4.uio_out[0]}, 8'h00);
`ifdef AES_LITE_DEBUG_EN
        check("uio_oe", if4.uio_oe, 8'hFD);
        check("reset_state", {6'b0, if4.uio_out[3:2]}, 8'h00);
`else
        check("uio_oe", if4.uio_oe, 8'h01);
        check("uio_out_upper", {1'b0, if4.uio_out[7:1]}, 8'h00);
`endif
    endtask

    task automatic txn(input logic [7:0] d, input logic [7:0] k, input logic [7:0] exp4,
                       input int gap_len, input bit scramble);
        int edges;
        edges = 0;
        start(d, k);
        while (if4.uio_out[0] !== 1'b1 && edges < 60) begin
            @(posedge clk); #1;
            edges++;
`ifdef AES_LITE_DEBUG_EN
            if (gap_len == 0)
                check("debug_state", {6'b0, if4.uio_out[3:2]},
                      (edges == 1) ? 8'd1 : (edges < 6) ? 8'd2 : 8'd3);
`endif
            if (scramble && edges >= 2) set_in(1'b1, 8'($urandom), 8'($urandom));
            if (gap_len > 0 && edges == 3) begin
                if1.ena = 1'b0; if2.ena = 1'b0; if4.ena = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge clk); #1;
                    edges++;
                    check("gap_ready_low", {7'b0, if4.uio_out[0]}, 8'h00);
`ifdef AES_LITE_DEBUG_EN
                    check("gap_round_count", {4'b0, if4.uio_out[7:4]}, 8'd2);
`endif
                end
                if1.ena = 1'b1; if2.ena = 1'b1; if4.ena = 1'b1;
            end
        end
        check("latency_edges", 8'(edges), 8'(6 + gap_len));
        for (int h = 0; h < 4; h++) begin
            if (scramble) set_in(1'b1, 8'($urandom), 8'($urandom));
            @(posedge clk); #1;
            check("done_hold_out", if4.uo_out, exp4);
            check("done_hold_ready", {7'b0, if4.uio_out[0]}, 8'h01);
        end
    endtask

    initial begin
        logic [7:0] d, k;
        for (int i = 0; i < 3; i++) prev_rdy[i] = 1'b0;
        set_in(1'b0, 8'h00, 8'h00);
        build_sbox();

        // Fixed vectors with hand-derived expectations.
        q[0].push_back(8'h37); q[1].push_back(8'hA9); q[2].push_back(8'h21);
        txn(8'h00, 8'h00, 8'h21, 0, 1'b0);
        q[0].push_back(8'hCA); q[1].push_back(model(8'hAA, 8'h55, 2)); q[2].push_back(model(8'hAA, 8'h55, 4));
        txn(8'hAA, 8'h55, model(8'hAA, 8'h55, 4), 0, 1'b0);
        push_model(8'h12, 8'h34); txn(8'h12, 8'h34, model(8'h12, 8'h34, 4), 0, 1'b0);
        push_model(8'hFF, 8'hFF); txn(8'hFF, 8'hFF, model(8'hFF, 8'hFF, 4), 0, 1'b0);
        push_model(8'h5A, 8'hA5); txn(8'h5A, 8'hA5, model(8'h5A, 8'hA5, 4), 0, 1'b0);

        // Reset in the middle of ROUND: only the shorter instances finish.
        start(8'h3C, 8'hC3);
        q[0].push_back(model(8'h3C, 8'hC3, 1));
        q[1].push_back(model(8'h3C, 8'hC3, 2));
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("abort_uo_out", if4.uo_out, 8'h00);
        check("abort_ready", {7'b0, if4.uio_out[0]}, 8'h00);
`ifdef AES_LITE_DEBUG_EN
        check("abort_state", {6'b0, if4.uio_out[3:2]}, 8'h00);
`endif
        rst = 1'b0;
        push_model(8'h77, 8'h88); txn(8'h77, 8'h88, model(8'h77, 8'h88, 4), 0, 1'b0);

        // Enable gap and input scrambling.
        push_model(8'hC4, 8'h1E); txn(8'hC4, 8'h1E, model(8'hC4, 8'h1E, 4), 5, 1'b0);
        push_model(8'h9B, 8'h60); txn(8'h9B, 8'h60, model(8'h9B, 8'h60, 4), 0, 1'b1);

        for (int n = 0; n < 8; n++) begin
            int gap;
            bit scr;
            d = 8'($urandom);
            k = 8'($urandom);
            gap = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
            scr = 1'($urandom_range(0, 1));
            push_model(d, k);
            txn(d, k, model(d, k, 4), gap, scr);
        end

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("queue_empty_r%0d", RND[i]), 8'(q[i].size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
